// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch front end. Reads one- or two-word
//                instructions from a synchronous instruction memory and
//                presents them to decode with a valid/ready handshake. It
//                waits for execute to resolve each JMPZ and stops at END.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   rising-edge clock for all state
//    reset        in   synchronous, active-high
//    start        in   pulse; starts fetching at address 0 from IDLE/HALT
//    MemControl   out  2'd1 = read, 2'd0 = idle
//    MemAddr      out  instruction-memory word address
//    MemInstr     in   read data, valid the cycle after a read command
//    instr_valid  out  instruction presented to decode
//    instr_ready  in   decode accepts (transfer when valid & ready)
//    instr_word   out  opcode word (opcode = bits [15:12])
//    instr_imm    out  immediate for LOAD/JMPZ, zero otherwise
//    instr_pc     out  address of instr_word
//    branch_done  in   execute resolved the outstanding JMPZ
//    branch_taken in   qualified by branch_done; jump to the JMPZ immediate
//    halted       out  high in HALT
//    busy         out  high in every state except IDLE and HALT
// ============================================================================
module instr_fetch_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [1:0]  MemControl,
    output logic [15:0] MemAddr,
    input  logic [15:0] MemInstr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_word,
    output logic [15:0] instr_imm,
    output logic [15:0] instr_pc,
    input  logic        branch_done,
    input  logic        branch_taken,
    output logic        halted,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ_OP   = 3'd1;
    localparam logic [2:0] ST_WAIT_OP  = 3'd2;
    localparam logic [2:0] ST_REQ_IMM  = 3'd3;
    localparam logic [2:0] ST_WAIT_IMM = 3'd4;
    localparam logic [2:0] ST_HOLD     = 3'd5;
    localparam logic [2:0] ST_BR_WAIT  = 3'd6;
    localparam logic [2:0] ST_HALT     = 3'd7;

    localparam logic [3:0] OP_END  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd4;
    localparam logic [3:0] OP_JMPZ = 4'd15;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_READ = 2'd1;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  mem_control_q, mem_control_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [15:0] instr_word_q, instr_word_d;
    logic [15:0] instr_imm_q, instr_imm_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        halted_q, halted_d;
    logic        busy_q, busy_d;

    logic        mem_two_word;
    logic        mem_rd;
    logic [3:0]  hold_op;

    // Opcode of the word arriving from memory decides whether an immediate follows.
    assign mem_two_word = (MemInstr[15:12] == OP_LOAD) || (MemInstr[15:12] == OP_JMPZ);
    assign hold_op      = instr_word_q[15:12];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_REQ_OP;
                end
            end
            ST_REQ_OP:   state_d = ST_WAIT_OP;
            ST_WAIT_OP:  state_d = mem_two_word ? ST_REQ_IMM : ST_HOLD;
            ST_REQ_IMM:  state_d = ST_WAIT_IMM;
            ST_WAIT_IMM: state_d = ST_HOLD;
            ST_HOLD: begin
                if (instr_ready) begin
                    if (hold_op == OP_END) begin
                        state_d = ST_HALT;
                    end else if (hold_op == OP_JMPZ) begin
                        state_d = ST_BR_WAIT;
                    end else begin
                        state_d = ST_REQ_OP;
                    end
                end
            end
            ST_BR_WAIT: begin
                if (branch_done) begin
                    state_d = ST_REQ_OP;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath logic. Outputs are registered, so each one is derived
    // from the state being entered (state_d) rather than the current state.
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        instr_word_d = instr_word_q;
        instr_imm_d  = instr_imm_q;
        instr_pc_d   = instr_pc_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d = 16'd0;
                end
            end
            ST_WAIT_OP: begin
                instr_word_d = MemInstr;
                instr_pc_d   = pc_q;
                pc_d         = pc_q + 16'd1;
                if (!mem_two_word) begin
                    instr_imm_d = 16'd0;
                end
            end
            ST_WAIT_IMM: begin
                instr_imm_d = MemInstr;
                pc_d        = pc_q + 16'd1;
            end
            ST_BR_WAIT: begin
                // Not taken: pc already points past the immediate word.
                if (branch_done && branch_taken) begin
                    pc_d = instr_imm_q;
                end
            end
            default: begin
            end
        endcase

        mem_rd        = (state_d == ST_REQ_OP) || (state_d == ST_REQ_IMM);
        mem_control_d = mem_rd ? MEM_READ : MEM_IDLE;
        mem_addr_d    = mem_rd ? pc_d : mem_addr_q;
        instr_valid_d = (state_d == ST_HOLD);
        halted_d      = (state_d == ST_HALT);
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_HALT);
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= 16'd0;
            mem_control_q <= MEM_IDLE;
            mem_addr_q    <= 16'd0;
            instr_valid_q <= 1'b0;
            instr_word_q  <= 16'd0;
            instr_imm_q   <= 16'd0;
            instr_pc_q    <= 16'd0;
            halted_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            mem_control_q <= mem_control_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_word_q  <= instr_word_d;
            instr_imm_q   <= instr_imm_d;
            instr_pc_q    <= instr_pc_d;
            halted_q      <= halted_d;
            busy_q        <= busy_d;
        end
    end

    assign MemControl  = mem_control_q;
    assign MemAddr     = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_word  = instr_word_q;
    assign instr_imm   = instr_imm_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high; when sampled high, all state and outputs go to reset values.
REQ-004 start  in  1  single-cycle pulse; begins fetch at address 0 from IDLE or HALT.
REQ-005 MemControl  out  2  instruction-memory command: 2'd1 = read, 2'd0 = idle; no other values are driven.
REQ-006 MemAddr  out  16  instruction-memory word address.
REQ-007 MemInstr  in  16  instruction-memory read data; holds ram[A] in the cycle after a cycle that presented MemControl=1 with MemAddr=A.
REQ-008 instr_valid  out  1  a decoded-ready instruction is presented to decode.
REQ-009 instr_ready  in  1  decode accepts; a transfer occurs in a cycle with instr_valid=1 and instr_ready=1.
REQ-010 instr_word  out  16  opcode word; opcode = bits [15:12].
REQ-011 instr_imm  out  16  immediate word for LOAD (4'd4) and JMPZ (4'd15); 16'd0 for all other opcodes.
REQ-012 instr_pc  out  16  address of instr_word.
REQ-013 branch_done  in  1  single-cycle pulse from execute that resolves the outstanding JMPZ.
REQ-014 branch_taken  in  1  qualified by branch_done; 1 = jump to the JMPZ immediate.
REQ-015 halted  out  1  high in HALT.
REQ-016 busy  out  1  high in every state except IDLE and HALT.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ_OP, WAIT_OP, REQ_IMM, WAIT_IMM, HOLD, BR_WAIT and HALT; all outputs are registered.
REQ-018 IDLE/HALT: MemControl=0; start -> pc<=0, go to REQ_OP.
REQ-019 REQ_OP: MemControl=1, MemAddr=pc for exactly one cycle; go to WAIT_OP.
REQ-020 WAIT_OP: capture MemInstr into instr_word, pc into instr_pc, pc<=pc+1; if opcode is LOAD or JMPZ, go to REQ_IMM; otherwise set instr_imm=0 and go to HOLD.
REQ-021 REQ_IMM: MemControl=1, MemAddr=pc for one cycle; go to WAIT_IMM.
REQ-022 WAIT_IMM: capture MemInstr into instr_imm, pc<=pc+1; go to HOLD.
REQ-023 HOLD: instr_valid=1; instr_word, instr_imm and instr_pc stay stable until transfer; no memory read is issued.
REQ-024 On transfer in HOLD: END (4'd1) -> HALT; JMPZ -> BR_WAIT; any other opcode -> REQ_OP. instr_valid drops the following cycle.
REQ-025 BR_WAIT: MemControl=0; on branch_done, pc<=instr_imm if branch_taken=1, otherwise pc is unchanged (already the address after the immediate); then go to REQ_OP.
REQ-026 Minimum latency: start -> first instr_valid = 3 cycles for a one-word instruction and 5 cycles for a two-word instruction; back-to-back one-word instructions with ready held high issue one instruction per 3 cycles.
REQ-027 pc SHALL be 16-bit and wrap from 16'hFFFF to 16'h0000 without error.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 branch_done SHALL be ignored outside BR_WAIT.
REQ-030 branch_taken SHALL be ignored when branch_done=0.
REQ-031 MemInstr SHALL be sampled only in WAIT_OP and WAIT_IMM.
REQ-032 NOP (4'd0) and all non-END, non-JMPZ opcodes SHALL be forwarded unchanged; the block performs no other decode.

Reset
REQ-033 While reset is sampled high: state<=IDLE, pc<=0, MemControl<=0, MemAddr<=0, instr_valid<=0, instr_word<=0, instr_imm<=0, instr_pc<=0, halted<=0, busy<=0.
REQ-034 Reset SHALL take priority over start, instr_ready and branch_done in the same cycle.
REQ-035 Reset mid-operation SHALL abandon any outstanding read; MemInstr returned after reset is ignored.

Verification
REQ-036 Reset, ram[0]=16'h207C, pulse start -> MemControl=1 with MemAddr=0 on the next cycle; instr_valid=1 with word=16'h207C, imm=0, pc=0 3 cycles after start.
REQ-037 ram[1]=16'h4004 (LOAD), ram[2]=16'h0000 -> one transfer with word=16'h4004, imm=0, pc=1; next read MemAddr=3.
REQ-038 instr_ready held low 5 cycles in HOLD -> instr_valid and payload stable, MemControl=0 throughout; one transfer when ready rises.
REQ-039 ram[51]=16'hF000 (JMPZ), ram[52]=16'h0080 -> BR_WAIT; branch_done=1 with taken=1 -> next read MemAddr=16'h0080; with taken=0 -> MemAddr=53; branch_done pulsed earlier while in HOLD is ignored.
REQ-040 END 16'h1000 transferred -> halted=1, busy=0, MemControl=0 indefinitely; start -> halted=0, read MemAddr=0.
REQ-041 Reset asserted in WAIT_IMM -> next cycle all outputs at reset values, state IDLE; pc=16'hFFFF one-word fetch -> next read MemAddr=0.
